// File: rtl/ram_be_sync.sv
// Single-port synchronous RAM with byte-lane writes, a registered read with a
// one-cycle valid strobe, and a post-reset sequencer that zeroes every word.
module ram_be_sync #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cen,
  input  logic              wen,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   initCnt_q, initCnt_d;
  logic [DATA_W-1:0]   dout_q;
  logic                doutValid_q;
  logic                clearEn;
  logic                userWrEn;
  logic                rdEn;

  logic [DATA_W-1:0]   mem [DEPTH];

  // State and clear-pointer registers; reset restarts the whole clear pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  // Bus accesses are only honoured once the clear pass has finished.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    clearEn   = 1'b0;
    userWrEn  = 1'b0;
    rdEn      = 1'b0;
    case (state_q)
      INIT: begin
        clearEn   = 1'b1;
        initCnt_d = initCnt_q + ADDR_W'(1);
        if (initCnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        userWrEn = cen & wen;
        rdEn     = cen & ~wen;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // The array itself is never reset; the INIT pass clears it instead.
  always_ff @(posedge clk) begin
    if (clearEn) begin
      mem[initCnt_q] <= '0;
    end else if (userWrEn) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q      <= '0;
      doutValid_q <= 1'b0;
    end else begin
      doutValid_q <= rdEn;
      if (rdEn) begin
        dout_q <= mem[addr];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign busy       = (state_q == INIT);

endmodule

// File: tb/tb_ram_be_sync.sv
// Directed self-checking bench for ram_be_sync: clear sequencer, byte-enable
// writes, registered reads, disabled accesses and mid-stream reset.
module tb_ram_be_sync;

  logic        clk;
  logic        reset;
  logic        cen;
  logic        wen;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ram_be_sync #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cen       (cen),
    .wen       (wen),
    .be        (be),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1ns after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    cen = 1'b1; wen = 1'b1; addr = a; din = d; be = b;
    tick();
    cen = 1'b0; wen = 1'b0;
  endtask

  task automatic doRead(input logic [4:0] a);
    cen = 1'b1; wen = 1'b0; addr = a;
    tick();
    cen = 1'b0;
  endtask

  task automatic doIdle();
    cen = 1'b0; wen = 1'b0;
    tick();
  endtask

  // Counts edges until busy falls, bounded so a stuck sequencer still ends.
  task automatic waitClear(output int edges);
    edges = 0;
    while (busy === 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    int edges;
    int badReads;
    reset = 1'b1;
    tick();
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_state: dout=%h valid=%b busy=%b, expected dout=0 valid=0 busy=1",
               dout, dout_valid, busy);
    end
    reset = 1'b0;
    waitClear(edges);
    checks++;
    if (edges != 32) begin
      failures++;
      $display("[TB] FAIL init_busy_edges: got %0d edges, expected 32", edges);
    end
    badReads = 0;
    for (int i = 0; i < 32; i++) begin
      doRead(5'(i));
      cen = 1'b1;
      if (dout !== 32'h0 || dout_valid !== 1'b1) badReads++;
    end
    cen = 1'b0;
    checks++;
    if (badReads != 0) begin
      failures++;
      $display("[TB] FAIL init_cleared_reads: %0d of 32 reads wrong, expected 0", badReads);
    end
    doIdle();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_valid: valid=%b, expected 0", dout_valid);
    end
  endtask

  task automatic test_full_write();
    logic [4:0]  addrs [4];
    logic [31:0] datas [4];
    addrs[0] = 5'h01; datas[0] = 32'h1234ABCD;
    addrs[1] = 5'h04; datas[1] = 32'h13572468;
    addrs[2] = 5'h10; datas[2] = 32'hF0F0F0F0;
    addrs[3] = 5'h1F; datas[3] = 32'hA5A55A5A;
    for (int i = 0; i < 4; i++) doWrite(addrs[i], datas[i], 4'hF);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL write_no_valid: dout=%h valid=%b, expected dout=0 valid=0", dout, dout_valid);
    end
    // Back-to-back reads: each result appears one edge after its request.
    for (int i = 0; i < 4; i++) begin
      doRead(addrs[i]);
      cen = 1'b1;
      checks++;
      if (dout !== datas[i] || dout_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL full_write_read[%0d]: dout=%h valid=%b, expected dout=%h valid=1",
                 i, dout, dout_valid, datas[i]);
      end
    end
    cen = 1'b0;
  endtask

  task automatic test_byte_enable();
    doWrite(5'h03, 32'hFFFFFFFF, 4'hF);
    doWrite(5'h03, 32'h11223344, 4'b0101);
    doRead(5'h03);
    checks++;
    if (dout !== 32'hFF22FF44 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL byte_enable_merge: dout=%h valid=%b, expected dout=ff22ff44 valid=1",
               dout, dout_valid);
    end
    doWrite(5'h03, 32'h00000000, 4'h0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'hFF22FF44) begin
      failures++;
      $display("[TB] FAIL write_holds_dout: dout=%h valid=%b, expected dout=ff22ff44 valid=0",
               dout, dout_valid);
    end
    doRead(5'h03);
    checks++;
    if (dout !== 32'hFF22FF44) begin
      failures++;
      $display("[TB] FAIL be_zero_no_change: dout=%h, expected ff22ff44", dout);
    end
  endtask

  task automatic test_chip_disable();
    doRead(5'h04);
    cen = 1'b0; wen = 1'b1; addr = 5'h03; din = 32'h1111FFFF; be = 4'hF;
    tick();
    wen = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'h13572468) begin
      failures++;
      $display("[TB] FAIL cen_low_hold: dout=%h valid=%b, expected dout=13572468 valid=0",
               dout, dout_valid);
    end
    doRead(5'h03);
    checks++;
    if (dout !== 32'hFF22FF44 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cen_low_no_write: dout=%h valid=%b, expected dout=ff22ff44 valid=1",
               dout, dout_valid);
    end
  endtask

  task automatic test_init_ignores_bus();
    int edges;
    int bad;
    doWrite(5'h05, 32'h5A5A5A5A, 4'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cen = 1'b1; wen = 1'b1; addr = 5'h05; din = 32'hDEADBEEF; be = 4'hF;
    edges = 0;
    bad = 0;
    while (busy === 1'b1 && edges < 40) begin
      tick();
      edges++;
      if (busy === 1'b1 && (dout_valid !== 1'b0 || dout !== 32'h0)) bad++;
    end
    cen = 1'b0; wen = 1'b0;
    checks++;
    if (edges != 32 || bad != 0) begin
      failures++;
      $display("[TB] FAIL init_outputs_quiet: edges=%0d bad=%0d, expected edges=32 bad=0", edges, bad);
    end
    doRead(5'h05);
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL init_write_ignored: dout=%h valid=%b, expected dout=0 valid=1",
               dout, dout_valid);
    end
  endtask

  task automatic test_mid_reset();
    int edges;
    doWrite(5'h08, 32'hCAFEF00D, 4'hF);
    doRead(5'h08);
    checks++;
    if (dout !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL pre_reset_read: dout=%h, expected cafef00d", dout);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset: dout=%h valid=%b busy=%b, expected dout=0 valid=0 busy=1",
               dout, dout_valid, busy);
    end
    tick();
    reset = 1'b0;
    waitClear(edges);
    checks++;
    if (edges != 32) begin
      failures++;
      $display("[TB] FAIL reinit_busy_edges: got %0d edges, expected 32", edges);
    end
    doRead(5'h08);
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reinit_cleared: dout=%h valid=%b, expected dout=0 valid=1",
               dout, dout_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    cen   = 1'b0;
    wen   = 1'b0;
    be    = 4'h0;
    addr  = 5'h0;
    din   = 32'h0;
    test_reset();
    test_full_write();
    test_byte_enable();
    test_chip_disable();
    test_init_ignores_bus();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
